// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU issue stage: opcode encodings, the issue
//   FSM state type, the default datapath width and small opcode classifiers.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'b1000; // A + B
  localparam logic [3:0] OP_INC  = 4'b0100; // B + 1
  localparam logic [3:0] OP_NEG  = 4'b0010; // -B
  localparam logic [3:0] OP_SUB  = 4'b0001; // B - A
  localparam logic [3:0] OP_PASS = 4'b1111; // B
  localparam logic [3:0] OP_NOP  = 4'b0000; // nothing

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Opcodes whose ALU result is written back to the register file.
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_PASS: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Arithmetic opcodes update Z/NEG; PASS and NOP leave them alone.
  function automatic logic op_sets_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_INC, OP_NEG, OP_SUB: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return op_writes(op) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREGS x DATA_W general register file.
//   Ports: clk, rst_n (async active-low clear of every entry);
//          ra_addr/ra_data, rb_addr/rb_data : combinational operand reads;
//          dbg_addr/dbg_data                : combinational debug read;
//          we/waddr/wdata                   : synchronous write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREGS  = 8,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [RA_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] rf_q [NREGS];

  // One flop bank per entry so the asynchronous clear maps onto plain
  // registers rather than a RAM macro.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_d;

    always_comb begin
      entry_d = rf_q[gi];
      if (we && (waddr == RA_W'(gi))) entry_d = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rf_q[gi] <= '0;
      else        rf_q[gi] <= entry_d;
    end
  end

  assign ra_data  = rf_q[ra_addr];
  assign rb_data  = rf_q[rb_addr];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Issue stage in front of a combinational ALU. Accepts one instruction per
//   valid/ready handshake, reads operands from the register file, presents
//   registered opcode/A/B to the ALU, writes the result back and maintains
//   the architectural Z/NEG flags. One instruction every three clocks.
//   Ports: clk, rst_n (async active-low);
//          instr_valid/instr_ready handshake with instr_op/rd/ra/rb/imm_en/imm;
//          alu_opcode/alu_a/alu_b to the ALU, alu_result back from it;
//          wb_valid/illegal_op single-cycle completion pulses;
//          flag_z/flag_neg architectural flags; dbg_addr/dbg_data debug read.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter  int NREGS  = 8,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_ra,
  input  logic [RA_W-1:0]   instr_rb,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic              illegal_op,
  output logic              flag_z,
  output logic              flag_neg,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q,      state_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_a_q,      alu_a_d;
  logic [DATA_W-1:0] alu_b_q,      alu_b_d;
  logic [RA_W-1:0]   rd_q,         rd_d;
  logic              wb_valid_q,   wb_valid_d;
  logic              illegal_q,    illegal_d;
  logic              flag_z_q,     flag_z_d;
  logic              flag_neg_q,   flag_neg_d;

  logic              rf_we;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;

  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr_ra),
    .ra_data  (ra_data),
    .rb_addr  (instr_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (alu_result)
  );

  // The registered alu_opcode doubles as the latched opcode of the
  // in-flight instruction, so no separate copy is kept.
  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rd_d         = rd_q;
    wb_valid_d   = 1'b0;
    illegal_d    = 1'b0;
    flag_z_d     = flag_z_q;
    flag_neg_d   = flag_neg_q;
    rf_we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          alu_opcode_d = instr_op;
          rd_d         = instr_rd;
          alu_a_d      = ra_data;
          alu_b_d      = instr_imm_en ? instr_imm : rb_data;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU output has settled for a full cycle; commit it.
        rf_we = op_writes(alu_opcode_q);
        if (op_sets_flags(alu_opcode_q)) begin
          flag_neg_d = alu_result[DATA_W-1];
          flag_z_d   = (alu_result == '0);
        end
        illegal_d  = !op_legal(alu_opcode_q);
        wb_valid_d = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_opcode_q <= OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rd_q         <= '0;
      wb_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_neg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rd_q         <= rd_d;
      wb_valid_q   <= wb_valid_d;
      illegal_q    <= illegal_d;
      flag_z_q     <= flag_z_d;
      flag_neg_q   <= flag_neg_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign illegal_op  = illegal_q;
  assign flag_z      = flag_z_q;
  assign flag_neg    = flag_neg_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Self-checking bench: a fixed vector table for the directed scenarios,
//   hand-written handshake and reset sequences, then random instructions
//   checked against an arithmetic reference model of the register file and
//   flags. A behavioural ALU sits alongside the DUT.
module tb_alu_issue_unit;

  localparam int NREGS  = 8;
  localparam int DATA_W = 32;
  localparam int RA_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [RA_W-1:0]   instr_rd, instr_ra, instr_rb;
  logic              instr_imm_en;
  logic [DATA_W-1:0] instr_imm;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              wb_valid, illegal_op, flag_z, flag_neg;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_unit #(.NREGS(NREGS), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_ra     (instr_ra),
    .instr_rb     (instr_rb),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .wb_valid     (wb_valid),
    .illegal_op   (illegal_op),
    .flag_z       (flag_z),
    .flag_neg     (flag_neg),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU. Non-writing opcodes produce a marker value so that a
  // spurious writeback becomes visible in the register file.
  always_comb begin
    case (alu_opcode)
      4'b1000: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_b + 32'd1;
      4'b0010: alu_result = 32'd0 - alu_b;
      4'b0001: alu_result = alu_b - alu_a;
      4'b1111: alu_result = alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic        imm_en;
    logic [31:0] imm;
    logic [31:0] exp_val;   // rf[rd] after writeback
    logic        exp_z, exp_neg, exp_ill;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] m_rf [NREGS];
  logic        m_z, m_neg;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_rf[i] = 32'd0;
    m_z   = 1'b0;
    m_neg = 1'b0;
  endtask

  // Apply one instruction through the handshake and check every stage.
  task automatic run_instr(input vec_t v, input bit use_tbl);
    logic [31:0] a, b, res, e_val;
    logic        wr, fl, ill, e_z, e_neg, e_ill;
    int          waited;
    a   = m_rf[v.ra];
    b   = v.imm_en ? v.imm : m_rf[v.rb];
    res = 32'd0;
    wr  = 1'b1; fl = 1'b1; ill = 1'b0;
    case (v.op)
      4'b1000: res = a + b;
      4'b0100: res = b + 32'd1;
      4'b0010: res = 32'd0 - b;
      4'b0001: res = b - a;
      4'b1111: begin res = b; fl = 1'b0; end
      4'b0000: begin wr = 1'b0; fl = 1'b0; end
      default: begin wr = 1'b0; fl = 1'b0; ill = 1'b1; end
    endcase
    if (wr) m_rf[v.rd] = res;
    if (fl) begin
      m_z   = (res == 32'd0);
      m_neg = res[31];
    end
    if (use_tbl) begin
      e_val = v.exp_val; e_z = v.exp_z; e_neg = v.exp_neg; e_ill = v.exp_ill;
    end else begin
      e_val = m_rf[v.rd]; e_z = m_z; e_neg = m_neg; e_ill = ill;
    end

    @(negedge clk);
    waited = 0;
    while (!instr_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
      return;
    end
    instr_op     = v.op;
    instr_rd     = v.rd;
    instr_ra     = v.ra;
    instr_rb     = v.rb;
    instr_imm_en = v.imm_en;
    instr_imm    = v.imm;
    dbg_addr     = v.rd;
    instr_valid  = 1'b1;

    @(posedge clk); #1;             // accept edge N
    instr_valid = 1'b0;
    chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, v.op});
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("ready_exec", {31'd0, instr_ready}, 32'd0);
    chk("wb_early", {31'd0, wb_valid}, 32'd0);

    @(posedge clk); #1;             // edge N+1: writeback done
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, e_ill});
    chk("flag_z", {31'd0, flag_z}, {31'd0, e_z});
    chk("flag_neg", {31'd0, flag_neg}, {31'd0, e_neg});
    chk("rf_rd", dbg_data, e_val);
    chk("ready_wb", {31'd0, instr_ready}, 32'd0);

    @(posedge clk); #1;             // edge N+2: back to idle
    chk("wb_clear", {31'd0, wb_valid}, 32'd0);
    chk("ill_clear", {31'd0, illegal_op}, 32'd0);
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);

    n_txn++;
    $display("txn %0d op=%b rd=%0d ra=%0d rb=%0d imm_en=%0d imm=%08h -> rf=%08h z=%0d n=%0d ill=%0d",
             n_txn, v.op, v.rd, v.ra, v.rb, v.imm_en, v.imm, dbg_data, flag_z, flag_neg, e_ill);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    chk({tag, "_opcode"}, {28'd0, alu_opcode}, 32'd0);
    chk({tag, "_a"}, alu_a, 32'd0);
    chk({tag, "_b"}, alu_b, 32'd0);
    chk({tag, "_wb"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal_op}, 32'd0);
    chk({tag, "_z"}, {31'd0, flag_z}, 32'd0);
    chk({tag, "_neg"}, {31'd0, flag_neg}, 32'd0);
    for (int r = 0; r < NREGS; r++) begin
      dbg_addr = RA_W'(r);
      #1;
      chk({tag, "_rf"}, dbg_data, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   sel;
    logic [3:0] legal_ops [6];

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'd0;
    instr_rd = '0; instr_ra = '0; instr_rb = '0;
    instr_imm_en = 1'b0; instr_imm = '0; dbg_addr = '0;
    model_reset();

    //        op       rd    ra    rb    ie    imm            val            z     n     ill
    tbl[0] = '{4'b1111, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'b1000, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'b0001, 3'd5, 3'd1, 3'd0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'b0010, 3'd6, 3'd0, 3'd1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'b1111, 3'd4, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{4'b0100, 3'd4, 3'd0, 3'd4, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{4'b1111, 3'd7, 3'd0, 3'd0, 1'b1, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{4'b0000, 3'd1, 3'd0, 3'd0, 1'b0, 32'h0000_0000, 32'h0000_0005, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{4'b0110, 3'd2, 3'd1, 3'd1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1};

    // Power-on reset
    repeat (2) @(posedge clk);
    #2;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) run_instr(tbl[i], 1'b1);

    // Valid held through EXEC/WB: only the IDLE edge accepts again.
    @(negedge clk);
    chk("hold_ready0", {31'd0, instr_ready}, 32'd1);
    instr_op = 4'b1111; instr_rd = 3'd1; instr_imm_en = 1'b1;
    instr_imm = 32'h0000_00AA; dbg_addr = 3'd1; instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("hold_b_acc", alu_b, 32'h0000_00AA);
    instr_imm = 32'h0000_00BB;
    @(posedge clk); #1;
    chk("hold_b_exec", alu_b, 32'h0000_00AA);
    chk("hold_wb", {31'd0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    chk("hold_b_wb", alu_b, 32'h0000_00AA);
    chk("hold_ready_idle", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("hold_b_reacc", alu_b, 32'h0000_00BB);
    chk("hold_ready_busy", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_wb2", {31'd0, wb_valid}, 32'd1);
    chk("hold_rf1", dbg_data, 32'h0000_00BB);
    @(posedge clk); #1;
    m_rf[1] = 32'h0000_00BB;
    $display("txn hold-valid sequence: rf[1]=%08h", dbg_data);

    // Random instructions against the reference model
    legal_ops[0] = 4'b1000; legal_ops[1] = 4'b0100; legal_ops[2] = 4'b0010;
    legal_ops[3] = 4'b0001; legal_ops[4] = 4'b1111; legal_ops[5] = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      sel       = $urandom_range(0, 9);
      rv.op     = (sel < 6) ? legal_ops[sel] : 4'($urandom_range(0, 15));
      rv.rd     = 3'($urandom_range(0, 7));
      rv.ra     = 3'($urandom_range(0, 7));
      rv.rb     = 3'($urandom_range(0, 7));
      rv.imm_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rv.imm = 32'hFFFF_FFFF;
        1:       rv.imm = 32'($urandom_range(0, 3));
        default: rv.imm = $urandom;
      endcase
      rv.exp_val = 32'd0; rv.exp_z = 1'b0; rv.exp_neg = 1'b0; rv.exp_ill = 1'b0;
      run_instr(rv, 1'b0);
    end

    // Reset asserted in the middle of EXEC: nothing gets written.
    @(negedge clk);
    instr_op = 4'b1111; instr_rd = 3'd5; instr_imm_en = 1'b1;
    instr_imm = 32'h0000_1234; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst_in_exec", {31'd0, instr_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dbg_addr = 3'd5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_wb", {31'd0, wb_valid}, 32'd0);
      chk("post_rst_rf5", dbg_data, m_rf[5]);
      chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    end
    $display("txn reset during EXEC: rf[5]=%08h ready=%0d", dbg_data, instr_ready);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
